// File: rtl/uart_baud_gen.sv
// uart_baud_gen: from a runtime divisor, makes a 3-per-bit centred RX sample strobe and a 1-per-bit TX strobe.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic             i_rxsync,
    output logic             o_rxpulse,
    output logic             o_txpulse
);
    logic             run;
    logic [DIV_W-1:0] div_in, rx_cnt, tx_cnt, rx_div, tx_div, rx_deff, tx_deff;
    logic [3:0]       rx_ph, tx_ph;
    logic             rx_clr, tx_clr, rx_tick, tx_tick;
    // The divisor seen in a count-0 cycle governs that whole tick, so use it directly there.
    always_comb begin
        div_in  = (i_divisor == '0) ? DIV_W'(1) : i_divisor;
        rx_deff = (rx_cnt == '0) ? div_in : rx_div;
        tx_deff = (tx_cnt == '0) ? div_in : tx_div;
        rx_tick = rx_cnt == rx_deff - DIV_W'(1);
        tx_tick = tx_cnt == tx_deff - DIV_W'(1);
        tx_clr  = !i_en || !run;
        rx_clr  = tx_clr || i_rxsync;
    end
    // The first enabled edge after reset or re-enable acts as a restart, so count 0 is the following cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            run       <= 1'b0;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            rx_div    <= '0;
            tx_div    <= '0;
            rx_ph     <= '0;
            tx_ph     <= '0;
            o_rxpulse <= 1'b0;
            o_txpulse <= 1'b0;
        end else begin
            run <= i_en;
            if (i_en && rx_cnt == '0) rx_div <= div_in;
            if (i_en && tx_cnt == '0) tx_div <= div_in;
            rx_cnt    <= (rx_clr || rx_tick) ? '0 : rx_cnt + DIV_W'(1);
            tx_cnt    <= (tx_clr || tx_tick) ? '0 : tx_cnt + DIV_W'(1);
            rx_ph     <= rx_clr ? 4'd0 : rx_ph + 4'(rx_tick);
            tx_ph     <= tx_clr ? 4'd0 : tx_ph + 4'(tx_tick);
            o_rxpulse <= !rx_clr && rx_tick && (rx_ph inside {[4'd7:4'd9]});
            o_txpulse <= !tx_clr && tx_tick && (tx_ph == 4'd15);
        end
    end
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed and random checks of uart_baud_gen against a tick-event reference model.
module tb_uart_baud_gen;
    logic        i_clk = 1'b0, i_rst = 1'b0, i_en = 1'b0, i_rxsync = 1'b0;
    logic [15:0] i_divisor = '0;
    logic        o_rxpulse, o_txpulse;
    int n_tests = 0, n_fail = 0;
    int e = 0, t0 = 0;
    int rxq[$], txq[$], ex[$];
    bit m_run = 1'b0;
    int m_start[2], m_deff[2], m_ph[2];
    bit exp_rx, exp_tx;

    uart_baud_gen #(.DIV_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_divisor(i_divisor),
        .i_rxsync(i_rxsync), .o_rxpulse(o_rxpulse), .o_txpulse(o_txpulse)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Each tick starts at a count-0 edge, latches max(div,1), and ends deff-1 edges later.
    task automatic model_edge(bit en, int div, bit sync);
        bit clr[2];
        int d;
        d = (div == 0) ? 1 : div;
        clr[0] = !en || !m_run || sync;
        clr[1] = !en || !m_run;
        exp_rx = 1'b0;
        exp_tx = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (clr[p]) begin
                m_start[p] = e + 1;
                m_ph[p] = 0;
            end else begin
                if (e == m_start[p]) m_deff[p] = d;
                if (e == m_start[p] + m_deff[p] - 1) begin
                    if (p == 0) exp_rx = (m_ph[0] >= 7 && m_ph[0] <= 9);
                    else exp_tx = (m_ph[1] == 15);
                    m_ph[p] = (m_ph[p] + 1) % 16;
                    m_start[p] = e + 1;
                end
            end
        end
        m_run = en;
    endtask

    task automatic step(bit en, int div, bit sync);
        i_en = en;
        i_divisor = 16'(div);
        i_rxsync = sync;
        @(posedge i_clk);
        model_edge(en, div, sync);
        e++;
        #1;
        chk("rxpulse", 32'(o_rxpulse), 32'(exp_rx));
        chk("txpulse", 32'(o_txpulse), 32'(exp_tx));
        if (o_rxpulse === 1'b1) rxq.push_back(e - t0);
        if (o_txpulse === 1'b1) txq.push_back(e - t0);
    endtask

    task automatic start();
        t0 = e;
        rxq.delete();
        txq.delete();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        #1;
        chk("rst_rx", 32'(o_rxpulse), 0);
        chk("rst_tx", 32'(o_txpulse), 0);
        m_run = 1'b0;
        #3;
        i_rst = 1'b0;
    endtask

    task automatic expect_q(string tag, int q[$], int want[$]);
        chk({tag, "_count"}, q.size(), want.size());
        for (int i = 0; i < q.size() && i < want.size(); i++) chk({tag, "_cycle"}, q[i], want[i]);
    endtask

    initial begin
        #2;
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 4, 0);
        start();
        step(1, 4, 1);
        for (int i = 1; i <= 110; i++) step(1, 4, 0);
        ex = {33, 37, 41, 97, 101, 105};
        expect_q("rx_div4", rxq, ex);
        do_reset();
        start();
        for (int i = 0; i < 200; i++) step(1, 4, i == 100);
        ex = {65, 129, 193};
        expect_q("tx_div4", txq, ex);
        for (int d = 0; d < 2; d++) begin
            step(0, d, 0);
            start();
            step(1, d, 1);
            for (int i = 1; i <= 29; i++) step(1, d, 0);
            ex = {9, 10, 11, 25, 26, 27};
            expect_q(d == 0 ? "rx_div0" : "rx_div1", rxq, ex);
        end
        start();
        step(1, 4, 1);
        for (int i = 1; i <= 50; i++) step(1, i >= 34 ? 8 : 4, 0);
        ex = {33, 37, 45};
        expect_q("rx_divchg", rxq, ex);
        start();
        step(1, 4, 1);
        for (int i = 1; i <= 80; i++) step(1, 4, i == 35);
        ex = {33, 68, 72, 76};
        expect_q("rx_sync35", rxq, ex);
        start();
        step(1, 4, 1);
        for (int i = 1; i <= 75; i++) step(1, 4, i == 32);
        ex = {65, 69, 73};
        expect_q("rx_sync_tick", rxq, ex);
        for (int i = 0; i < 20; i++) step(1, 4, 0);
        for (int i = 0; i < 10; i++) step(0, 4, 0);
        start();
        for (int i = 0; i <= 70; i++) step(1, 4, 0);
        ex = {33, 37, 41};
        expect_q("rx_reen", rxq, ex);
        ex = {65};
        expect_q("tx_reen", txq, ex);
        start();
        step(1, 4, 1);
        for (int i = 1; i <= 32; i++) step(1, 4, 0);
        chk("rx_pending", 32'(o_rxpulse), 1);
        do_reset();
        start();
        for (int i = 0; i <= 70; i++) step(1, 4, 0);
        ex = {33, 37, 41};
        expect_q("rx_rst", rxq, ex);
        ex = {65};
        expect_q("tx_rst", txq, ex);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 19) != 0, $urandom_range(0, 5), $urandom_range(0, 49) == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
